// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - Requester, shared-memory and status signals of mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          m_valid;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_ready;
  logic [DW-1:0] m_rdata;
  logic          stall_if;
  logic          stall_d;
  logic          err;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_ready, m_rdata,
    output if_rdata, if_done, d_rdata, d_done, m_valid, m_we, m_addr, m_wdata,
           stall_if, stall_d, err
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_ready, m_rdata,
    input  if_rdata, if_done, d_rdata, d_done, m_valid, m_we, m_addr, m_wdata,
           stall_if, stall_d, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - Fetch/data arbiter onto one memory port with watchdog
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.master bus
);
  localparam int            CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);
  localparam logic [DW-1:0] NOP    = DW'(32'h0000_0013);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] hold_addr, hold_addr_nxt;
  logic [DW-1:0] hold_wdata, hold_wdata_nxt;
  logic          hold_we, hold_we_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  logic          err_q, err_nxt;
  logic          grant_d, grant_any;
  logic          complete, abort, if_done, d_done;

  assign grant_any = bus.d_req | bus.if_req;

`ifdef ARB_ROUND_ROBIN_EN
  // last_d=0 after reset so the first tie goes to the data port
  logic last_d;
  assign grant_d = bus.d_req & (~bus.if_req | ~last_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d <= 1'b0;
    end else if (state == IDLE && grant_any) begin
      last_d <= grant_d;
    end
  end
`else
  assign grant_d = bus.d_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold_addr  <= '0;
      hold_wdata <= '0;
      hold_we    <= 1'b0;
      wait_cnt   <= '0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_addr  <= hold_addr_nxt;
      hold_wdata <= hold_wdata_nxt;
      hold_we    <= hold_we_nxt;
      wait_cnt   <= wait_cnt_nxt;
      err_q      <= err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    hold_addr_nxt  = hold_addr;
    hold_wdata_nxt = hold_wdata;
    hold_we_nxt    = hold_we;
    wait_cnt_nxt   = wait_cnt;
    err_nxt        = err_q;
    complete       = 1'b0;
    abort          = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_any) begin
          state_nxt      = grant_d ? DATA : FETCH;
          hold_addr_nxt  = grant_d ? bus.d_addr : bus.if_addr;
          hold_wdata_nxt = grant_d ? bus.d_wdata : '0;
          hold_we_nxt    = grant_d & bus.d_we;
          wait_cnt_nxt   = '0;
        end
      end
      FETCH, DATA: begin
        complete = bus.m_ready;
        // a late m_ready in the abort cycle still wins over the watchdog
        abort    = (TIMEOUT > 0) && !bus.m_ready && (wait_cnt == TO_VAL);
        if (complete || abort) begin
          state_nxt = IDLE;
        end else if (wait_cnt != '1) begin
          wait_cnt_nxt = wait_cnt + CW'(1);
        end
        if (abort) begin
          err_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign if_done      = (state == FETCH) && (complete || abort);
  assign d_done       = (state == DATA) && (complete || abort);

  assign bus.m_valid  = (state != IDLE);
  assign bus.m_we     = hold_we;
  assign bus.m_addr   = hold_addr;
  assign bus.m_wdata  = hold_wdata;
  assign bus.if_done  = if_done;
  assign bus.d_done   = d_done;
  assign bus.if_rdata = !if_done ? '0 : (complete ? bus.m_rdata : NOP);
  assign bus.d_rdata  = (d_done && complete) ? bus.m_rdata : '0;
  assign bus.stall_if = bus.if_req & ~if_done;
  assign bus.stall_d  = bus.d_req & ~d_done;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - Directed and randomized bench for mem_port_arbiter against a transaction model
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: who owns the port, what was latched, how many wait cycles elapsed
  int          owner = 0;
  logic [31:0] c_addr = '0;
  logic [31:0] c_wdata = '0;
  logic        c_we = 1'b0;
  int          age = 0;
  bit          err_m = 1'b0;
  bit          last_d = 1'b0;

  always @(negedge clk) begin
    bit          take_d, cmp, abt, fin;
    logic [31:0] e_rd;
    if (!rst_n) begin
      chk1("rst_m_valid", bus.m_valid, 1'b0);
      chk1("rst_m_we", bus.m_we, 1'b0);
      chk1("rst_if_done", bus.if_done, 1'b0);
      chk1("rst_d_done", bus.d_done, 1'b0);
      chk1("rst_err", bus.err, 1'b0);
      chk("rst_m_addr", bus.m_addr, 32'h0);
      chk("rst_m_wdata", bus.m_wdata, 32'h0);
      chk("rst_if_rdata", bus.if_rdata, 32'h0);
      chk("rst_d_rdata", bus.d_rdata, 32'h0);
      owner = 0; age = 0; err_m = 1'b0; last_d = 1'b0;
      c_addr = '0; c_wdata = '0; c_we = 1'b0;
    end else begin
      chk1("m_valid", bus.m_valid, owner != 0);
      chk1("err", bus.err, err_m);
      if (owner == 0) begin
        chk1("idle_if_done", bus.if_done, 1'b0);
        chk1("idle_d_done", bus.d_done, 1'b0);
        chk("idle_if_rdata", bus.if_rdata, 32'h0);
        chk("idle_d_rdata", bus.d_rdata, 32'h0);
        chk1("idle_stall_if", bus.stall_if, bus.if_req);
        chk1("idle_stall_d", bus.stall_d, bus.d_req);
        if (bus.d_req || bus.if_req) begin
          take_d  = bus.d_req && (!bus.if_req || !(RR && last_d));
          owner   = take_d ? 2 : 1;
          last_d  = take_d;
          c_addr  = take_d ? bus.d_addr : bus.if_addr;
          c_wdata = bus.d_wdata;
          c_we    = take_d && bus.d_we;
          age     = 0;
        end
      end else begin
        cmp  = bus.m_ready;
        abt  = !bus.m_ready && (age == TO);
        fin  = cmp || abt;
        e_rd = cmp ? bus.m_rdata : ((abt && owner == 1) ? 32'h0000_0013 : 32'h0);
        chk("m_addr", bus.m_addr, c_addr);
        chk1("m_we", bus.m_we, c_we);
        if (owner == 2) chk("m_wdata", bus.m_wdata, c_wdata);
        chk1("if_done", bus.if_done, owner == 1 && fin);
        chk1("d_done", bus.d_done, owner == 2 && fin);
        chk("if_rdata", bus.if_rdata, (owner == 1 && fin) ? e_rd : 32'h0);
        chk("d_rdata", bus.d_rdata, (owner == 2 && fin) ? e_rd : 32'h0);
        chk1("stall_if", bus.stall_if, bus.if_req && !(owner == 1 && fin));
        chk1("stall_d", bus.stall_d, bus.d_req && !(owner == 2 && fin));
        if (abt) err_m = 1'b1;
        if (fin) owner = 0;
        else age++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #2;
  endtask

  bit seen_if, seen_d;

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.m_ready = 1'b0; bus.m_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk1("reset_m_valid", bus.m_valid, 1'b0);
    chk1("reset_err", bus.err, 1'b0);
    rst_n = 1'b1;

    // single fetch, ready on first m_valid cycle
    step(); bus.if_req = 1'b1; bus.if_addr = 32'h100;
    look(); chk1("f1_stall_req", bus.stall_if, 1'b1); chk1("f1_no_valid", bus.m_valid, 1'b0);
    step(); bus.m_ready = 1'b1; bus.m_rdata = 32'hA5A5_0001;
    look(); chk1("f1_valid", bus.m_valid, 1'b1); chk("f1_addr", bus.m_addr, 32'h100);
    chk1("f1_done", bus.if_done, 1'b1); chk("f1_rdata", bus.if_rdata, 32'hA5A5_0001);
    chk1("f1_stall_done", bus.stall_if, 1'b0); chk1("f1_we", bus.m_we, 1'b0);
    step(); bus.if_req = 1'b0; bus.m_ready = 1'b0;
    look(); chk1("f1_idle", bus.m_valid, 1'b0); chk1("f1_done_off", bus.if_done, 1'b0);
    chk("f1_rdata_off", bus.if_rdata, 32'h0); chk1("f1_stall_off", bus.stall_if, 1'b0);

    // simultaneous store and fetch
    step(); bus.if_req = 1'b1; bus.if_addr = 32'h300;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200; bus.d_wdata = 32'hDEAD_BEEF;
    look(); chk1("t_stall_if0", bus.stall_if, 1'b1); chk1("t_stall_d0", bus.stall_d, 1'b1);
    step(); bus.d_addr = 32'h999; bus.d_wdata = 32'h1;
    look(); chk1("t_valid", bus.m_valid, 1'b1); chk1("t_we", bus.m_we, 1'b1);
    chk("t_addr", bus.m_addr, 32'h200); chk("t_wdata", bus.m_wdata, 32'hDEAD_BEEF);
    chk1("t_d_done0", bus.d_done, 1'b0); chk1("t_stall_if1", bus.stall_if, 1'b1);
    step();
    look(); chk("t_addr_hold", bus.m_addr, 32'h200); chk("t_wdata_hold", bus.m_wdata, 32'hDEAD_BEEF);
    step(); bus.m_ready = 1'b1; bus.m_rdata = 32'h1122_3344;
    look(); chk1("t_d_done", bus.d_done, 1'b1); chk("t_d_rdata", bus.d_rdata, 32'h1122_3344);
    chk1("t_stall_d", bus.stall_d, 1'b0); chk1("t_stall_if2", bus.stall_if, 1'b1);
    chk1("t_if_done0", bus.if_done, 1'b0);
    step(); bus.m_ready = 1'b0; bus.d_req = RR; bus.d_we = 1'b0; bus.d_addr = 32'h400;
    look(); chk1("t_gap", bus.m_valid, 1'b0); chk1("t_stall_if3", bus.stall_if, 1'b1);
    step(); bus.m_ready = 1'b1; bus.m_rdata = 32'h5566_7788;
    look(); chk("t_f_addr", bus.m_addr, 32'h300); chk1("t_if_done", bus.if_done, 1'b1);
    chk("t_if_rdata", bus.if_rdata, 32'h5566_7788); chk1("t_d_done1", bus.d_done, 1'b0);
    chk1("t_stall_d_rr", bus.stall_d, RR);
    step(); bus.if_req = 1'b0; bus.d_req = 1'b0; bus.m_ready = 1'b0;

    // m_ready exactly in the abort cycle completes normally
    step(); bus.if_req = 1'b1; bus.if_addr = 32'h600;
    for (int k = 1; k <= TO; k++) begin
      step(); look(); chk1("late_wait", bus.if_done, 1'b0);
    end
    step(); bus.m_ready = 1'b1; bus.m_rdata = 32'hCAFE_0001;
    look(); chk1("late_done", bus.if_done, 1'b1); chk("late_rdata", bus.if_rdata, 32'hCAFE_0001);
    step(); bus.if_req = 1'b0; bus.m_ready = 1'b0;
    look(); chk1("late_err", bus.err, 1'b0);

    // watchdog abort of a fetch
    step(); bus.if_req = 1'b1; bus.if_addr = 32'h680;
    for (int k = 1; k <= TO; k++) begin
      step(); look(); chk1("wd_wait", bus.if_done, 1'b0); chk1("wd_err0", bus.err, 1'b0);
    end
    step();
    look(); chk1("wd_done", bus.if_done, 1'b1); chk("wd_nop", bus.if_rdata, 32'h0000_0013);
    step(); bus.if_req = 1'b0;
    look(); chk1("wd_err1", bus.err, 1'b1); chk1("wd_idle", bus.m_valid, 1'b0);
    repeat (3) step();
    look(); chk1("wd_err_sticky", bus.err, 1'b1);

    // reset in the middle of a load wait
    step(); bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h700;
    step(); step();
    look(); chk1("rs_valid_pre", bus.m_valid, 1'b1);
    rst_n = 1'b0; bus.d_req = 1'b0;
    #1; chk1("rs_valid", bus.m_valid, 1'b0); chk1("rs_d_done", bus.d_done, 1'b0);
    chk1("rs_err", bus.err, 1'b0); chk("rs_addr", bus.m_addr, 32'h0);
    repeat (2) step();
    rst_n = 1'b1; bus.d_req = 1'b1; bus.d_addr = 32'h704;
    look(); chk1("rs_idle", bus.m_valid, 1'b0); chk1("rs_d_done1", bus.d_done, 1'b0);
    step(); bus.m_ready = 1'b1; bus.m_rdata = 32'h0BAD_F00D;
    look(); chk1("rs_valid2", bus.m_valid, 1'b1); chk("rs_addr2", bus.m_addr, 32'h704);
    chk1("rs_done", bus.d_done, 1'b1); chk("rs_rdata", bus.d_rdata, 32'h0BAD_F00D);
    step(); bus.d_req = 1'b0; bus.m_ready = 1'b0;

    // randomized traffic: requesters hold until done, inputs wiggle while held
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      seen_if = bus.if_done;
      seen_d  = bus.d_done;
      @(posedge clk);
      #1;
      if (!bus.if_req || seen_if) begin
        bus.if_req  = ($urandom_range(0, 2) != 0);
        bus.if_addr = $urandom;
      end else if ($urandom_range(0, 3) == 0) begin
        bus.if_addr = $urandom;
      end
      if (!bus.d_req || seen_d) begin
        bus.d_req   = ($urandom_range(0, 2) != 0);
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
      end else if ($urandom_range(0, 3) == 0) begin
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
      end
      bus.m_ready = ($urandom_range(0, 9) < 4);
      bus.m_rdata = $urandom;
    end

    @(negedge clk);
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter AW, 32, address width of all address ports.
REQ-002 Parameter DW, 32, data width of all data ports.
REQ-003 Parameter TIMEOUT, 64, maximum wait cycles for m_ready; 0 disables the watchdog.
REQ-004 Port clk  in  1  single clock; all state on rising edge.
REQ-005 Port rst_n  in  1  asynchronous, active-low reset.
REQ-006 Ports if_req in 1, if_addr in AW: instruction-fetch request and its address.
REQ-007 Ports if_rdata out DW, if_done out 1: fetch data, valid in the single completion cycle.
REQ-008 Ports d_req in 1, d_we in 1, d_addr in AW, d_wdata in DW: load/store request.
REQ-009 Ports d_rdata out DW, d_done out 1: load data, valid in the single completion cycle.
REQ-010 Ports m_valid out 1, m_we out 1, m_addr out AW, m_wdata out DW: shared memory command.
REQ-011 Ports m_ready in 1, m_rdata in DW: memory completion and read data.
REQ-012 Ports stall_if out 1, stall_d out 1: pipeline stall requests to the hazard logic.
REQ-013 Port err out 1: sticky watchdog error flag.

Function
REQ-014 FSM states: IDLE, FETCH, DATA; state, command holding registers and wait counter are registered.
REQ-015 IDLE with any request: latch the winner's address, wdata and we (0 for fetch); next state FETCH or DATA.
REQ-016 Fixed priority on simultaneous requests: d_req wins over if_req.
REQ-017 m_valid=1 exactly in FETCH/DATA; m_addr, m_wdata and m_we come from the holding registers and stay stable until completion.
REQ-018 Requester inputs that change after latching are ignored until the next IDLE.
REQ-019 Completion is the cycle with m_valid and m_ready both 1.
- Owner's done=1 combinationally in that cycle.
- Owner's rdata=m_rdata in that cycle.
- Next state is IDLE.
REQ-020 Latency: request in cycle N gives m_valid in N+1; earliest done in N+1; next grant no earlier than the cycle after completion.
REQ-021 if_rdata/d_rdata = 0 whenever the corresponding done is 0.
REQ-022 stall_if = if_req & ~if_done; stall_d = d_req & ~d_done; both combinational.
REQ-023 Wait counter:
- Cleared on entering FETCH/DATA.
- Increments each m_valid cycle without m_ready.
- Saturates; never wraps.
REQ-024 Watchdog (TIMEOUT>0): when the counter equals TIMEOUT and m_ready=0, abort.
- Owner's done=1 in that cycle.
- if_rdata=32'h00000013 (NOP) for a fetch; d_rdata=0 for a load.
- Set err; go to IDLE.
REQ-025 m_ready arriving in the abort cycle counts as normal completion; no abort, err unchanged.
REQ-026 err stays 1 until reset.
REQ-027 m_ready while m_valid=0 is ignored.

Reset
REQ-028 rst_n low immediately forces IDLE, even mid-transaction.
REQ-029 Reset clears holding registers, counter, err and last-grant flag.
REQ-030 During reset m_valid, m_we, if_done, d_done, err = 0; m_addr, m_wdata, if_rdata, d_rdata = 0.
REQ-031 A transaction interrupted by reset is dropped without a done pulse.

Configuration
REQ-032 Macro ARB_ROUND_ROBIN_EN defined: a last-grant flag, updated at each grant, gives simultaneous requests to the requester not granted last (first tie after reset goes to data).
REQ-033 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority per REQ-016; no last-grant flag is implemented.

Verification
REQ-034 if_req=1, if_addr=0x100, m_ready=1 at first m_valid -> m_valid 1 cycle later, m_addr=0x100, if_done pulse with if_rdata=m_rdata, stall_if=1 only in request cycle.
REQ-035 if_req and d_req both 1, d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, m_ready after 3 cycles -> DATA first, m_we=1, stall_if=1 throughout, then fetch granted; with ARB_ROUND_ROBIN_EN a second tie grants fetch first.
REQ-036 TIMEOUT=4, fetch with m_ready held 0 -> abort in the 5th m_valid cycle, if_done=1, if_rdata=0x00000013, err=1 held until reset.
REQ-037 TIMEOUT=4, m_ready=1 exactly in the abort cycle -> normal completion, err stays 0.
REQ-038 rst_n low 2 cycles into a DATA wait -> m_valid drops immediately, no d_done, IDLE after release, next d_req served normally.
